// File: rtl/jk_ff_controller.sv
// Round-robin command sequencer for a JK master-slave flip-flop: arbitrates two
// requesters, pulses J/K per repetition, waits for settling, then reports Q.
module jk_ff_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_VALID,
  input  logic [1:0]       REQ0_CMD,
  input  logic [CNT_W-1:0] REQ0_CNT,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [1:0]       REQ1_CMD,
  input  logic [CNT_W-1:0] REQ1_CNT,
  output logic             REQ1_READY,
  output logic             JM,
  output logic             KM,
  input  logic             QS,
  output logic             BUSY,
  output logic             DONE,
  output logic             DONE_ID,
  output logic             DONE_Q
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_APPLY  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [3:0]       WAIT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic             ptr;
  logic [1:0]       cmd_r;
  logic [CNT_W-1:0] rem;
  logic             id_r;
  logic [3:0]       wait_cnt;

  logic             grant0;
  logic             grant1;
  logic             handshake;
  logic             sel_id;
  logic [1:0]       sel_cmd;
  logic [CNT_W-1:0] sel_cnt;

  // PTR only matters when both requesters are valid at once
  always_comb begin
    grant0 = REQ0_VALID & (~REQ1_VALID | ~ptr);
    grant1 = REQ1_VALID & (~REQ0_VALID |  ptr);
  end

  assign REQ0_READY = (state == S_IDLE) & grant0;
  assign REQ1_READY = (state == S_IDLE) & grant1;
  assign handshake  = REQ0_READY | REQ1_READY;
  assign sel_id     = REQ1_READY;
  assign sel_cmd    = sel_id ? REQ1_CMD : REQ0_CMD;
  assign sel_cnt    = sel_id ? REQ1_CNT : REQ0_CNT;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      ptr      <= 1'b0;
      cmd_r    <= 2'b00;
      rem      <= '0;
      id_r     <= 1'b0;
      wait_cnt <= '0;
      JM       <= 1'b0;
      KM       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      DONE_ID  <= 1'b0;
      DONE_Q   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (handshake) begin
            cmd_r <= sel_cmd;
            rem   <= (sel_cnt == '0) ? CNT_ONE : sel_cnt;
            id_r  <= sel_id;
            ptr   <= ~sel_id;
            JM    <= sel_cmd[1];
            KM    <= sel_cmd[0];
            BUSY  <= 1'b1;
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          rem      <= rem - CNT_ONE;
          JM       <= 1'b0;
          KM       <= 1'b0;
          wait_cnt <= WAIT_LAST;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            if (rem != '0) begin
              JM    <= cmd_r[1];
              KM    <= cmd_r[0];
              state <= S_APPLY;
            end else begin
              // QS has had the full settle window since the last pulse
              DONE_Q  <= QS;
              DONE_ID <= id_r;
              DONE    <= 1'b1;
              state   <= S_REPORT;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_REPORT: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_ff_controller.sv
// Bench for jk_ff_controller: behavioural JK flip-flop plant, expected completions
// queued at handshake and checked when DONE fires.
module tb_jk_ff_controller;
  localparam int S     = 2;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             REQ0_VALID, REQ1_VALID;
  logic [1:0]       REQ0_CMD, REQ1_CMD;
  logic [CNT_W-1:0] REQ0_CNT, REQ1_CNT;
  logic             REQ0_READY, REQ1_READY;
  logic             JM, KM, QS, BUSY, DONE, DONE_ID, DONE_Q;

  jk_ff_controller #(.SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_CMD(REQ0_CMD), .REQ0_CNT(REQ0_CNT), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_CMD(REQ1_CMD), .REQ1_CNT(REQ1_CNT), .REQ1_READY(REQ1_READY),
    .JM(JM), .KM(KM), .QS(QS), .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID), .DONE_Q(DONE_Q)
  );

  always #5 CLK = ~CLK;

  logic q_plant = 1'b0;
  assign QS = q_plant;
  always @(posedge CLK) begin
    case ({JM, KM})
      2'b01:   q_plant <= 1'b0;
      2'b10:   q_plant <= 1'b1;
      2'b11:   q_plant <= ~q_plant;
      default: q_plant <= q_plant;
    endcase
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int both_rdy = 0;
  always @(negedge CLK) begin
    #2;
    if (REQ0_READY && REQ1_READY) both_rdy = both_rdy + 1;
  end

  typedef struct { logic id; logic q; } exp_t;
  exp_t sb[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic model_q  = 1'b0;

  function automatic logic next_q(input logic q, input logic [1:0] c, input int n);
    case (c)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return q ^ n[0];
    endcase
  endfunction

  task automatic set_req(input int r, input logic v, input logic [1:0] c, input logic [CNT_W-1:0] n);
    if (r == 0) begin REQ0_VALID = v; REQ0_CMD = c; REQ0_CNT = n; end
    else        begin REQ1_VALID = v; REQ1_CMD = c; REQ1_CNT = n; end
  endtask

  // Waits (bounded) for a grant, then queues the expected completion.
  task automatic wait_grant(input string name, input int exp_id, output int t,
                            output logic [1:0] c, output int neff);
    int b = 0;
    int id = -1;
    logic [CNT_W-1:0] n;
    t = 0; c = 2'b00; neff = 1;
    while (b < 40) begin
      #1;
      if (REQ0_READY || REQ1_READY) begin
        id = REQ1_READY ? 1 : 0;
        t  = cyc;
        break;
      end
      @(negedge CLK);
      b++;
    end
    n_checks++;
    if (id != exp_id) begin
      n_fail++;
      $display("FAIL %s grant: got id %0d required %0d", name, id, exp_id);
    end
    if (id >= 0) begin
      c    = (id == 1) ? REQ1_CMD : REQ0_CMD;
      n    = (id == 1) ? REQ1_CNT : REQ0_CNT;
      neff = (n == 0) ? 1 : int'(n);
      model_q = next_q(model_q, c, neff);
      sb.push_back('{id: id[0], q: model_q});
    end
  endtask

  // Called just after the handshake edge; checks every cycle through REPORT.
  task automatic run_check(input string name, input int t, input logic [1:0] c, input int neff);
    int d = neff * (1 + S) + 1;
    logic ej, ek;
    exp_t e;
    for (int k = 1; k <= d; k++) begin
      @(negedge CLK); #2;
      ej = (((k - 1) % (1 + S)) == 0 && k < d) ? c[1] : 1'b0;
      ek = (((k - 1) % (1 + S)) == 0 && k < d) ? c[0] : 1'b0;
      n_checks++;
      if ({JM, KM, BUSY, DONE} !== {ej, ek, 1'b1, (k == d)}) begin
        n_fail++;
        $display("FAIL %s cycle t+%0d JM/KM/BUSY/DONE: got %b required %b",
                 name, cyc - t, {JM, KM, BUSY, DONE}, {ej, ek, 1'b1, (k == d)});
      end
      if (k == d) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL %s scoreboard: got empty queue required one entry", name);
        end else begin
          e = sb.pop_front();
          if ({DONE_ID, DONE_Q} !== {e.id, e.q}) begin
            n_fail++;
            $display("FAIL %s DONE_ID/DONE_Q: got %b required %b", name, {DONE_ID, DONE_Q}, {e.id, e.q});
          end
        end
      end
    end
    @(negedge CLK); #2;
    n_checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s after REPORT BUSY/DONE: got %b required 00", name, {BUSY, DONE});
    end
  endtask

  task automatic single_cmd(input string name, input int r, input logic [1:0] c, input logic [CNT_W-1:0] n);
    int t, neff;
    logic [1:0] cc;
    @(negedge CLK);
    set_req(r, 1'b1, c, n);
    wait_grant(name, r, t, cc, neff);
    @(posedge CLK); #1;
    set_req(r, 1'b0, 2'b00, '0);
    run_check(name, t, cc, neff);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    n_checks++;
    if ({JM, KM, BUSY, DONE, DONE_ID, DONE_Q, REQ0_READY, REQ1_READY} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b required 00000000",
               {JM, KM, BUSY, DONE, DONE_ID, DONE_Q, REQ0_READY, REQ1_READY});
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    single_cmd("set_cnt1", 0, 2'b10, 4'd1);
  endtask

  task automatic test_cnt_zero();
    single_cmd("reset_cnt0", 0, 2'b01, 4'd0);
  endtask

  task automatic test_toggle();
    single_cmd("toggle_cnt3", 1, 2'b11, 4'd3);
  endtask

  task automatic test_hold();
    single_cmd("hold_cnt2", 1, 2'b00, 4'd2);
  endtask

  task automatic test_back_to_back();
    int t, neff;
    logic [1:0] cc;
    int exp_ids[3] = '{0, 1, 0};
    single_cmd("rr_prep", 0, 2'b00, 4'd1);
    apply_reset();
    both_rdy = 0;
    @(negedge CLK);
    set_req(0, 1'b1, 2'b10, 4'd1);
    set_req(1, 1'b1, 2'b01, 4'd1);
    for (int i = 0; i < 3; i++) begin
      wait_grant("round_robin", exp_ids[i], t, cc, neff);
      @(posedge CLK); #1;
      run_check("round_robin", t, cc, neff);
    end
    set_req(0, 1'b0, 2'b00, '0);
    set_req(1, 1'b0, 2'b00, '0);
    n_checks++;
    if (both_rdy != 0) begin
      n_fail++;
      $display("FAIL both_ready: got %0d cycles required 0", both_rdy);
    end
  endtask

  task automatic test_abort();
    int t, neff, done_seen;
    logic [1:0] cc;
    @(negedge CLK);
    set_req(0, 1'b1, 2'b11, 4'd2);
    wait_grant("abort", 0, t, cc, neff);
    @(posedge CLK); #1;
    set_req(0, 1'b0, 2'b00, '0);
    void'(sb.pop_back());
    model_q = ~next_q(model_q, 2'b11, 2);
    @(negedge CLK); #2;
    n_checks++;
    if ({JM, KM} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort apply JM/KM: got %b required 11", {JM, KM});
    end
    @(negedge CLK); #1;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({JM, KM, BUSY} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort immediate JM/KM/BUSY: got %b required 000", {JM, KM, BUSY});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge CLK); #2;
      if (DONE) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL abort no_done: got %0d DONE cycles required 0", done_seen);
    end
    single_cmd("after_abort_req1", 1, 2'b00, 4'd1);
    @(negedge CLK);
    set_req(0, 1'b1, 2'b10, 4'd1);
    set_req(1, 1'b1, 2'b01, 4'd1);
    wait_grant("after_abort_both", 0, t, cc, neff);
    @(posedge CLK); #1;
    set_req(0, 1'b0, 2'b00, '0);
    set_req(1, 1'b0, 2'b00, '0);
    run_check("after_abort_both", t, cc, neff);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    set_req(0, 1'b0, 2'b00, '0);
    set_req(1, 1'b0, 2'b00, '0);
    test_reset();
    test_cnt_zero();
    test_toggle();
    test_hold();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
